// File: rtl/csr_unit.sv
// Control/status register file: exception/ertn sink, CSR read/write port, constant timer,
// and redirect targets plus pending-interrupt flag for the front end.
module csr_unit #(
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  localparam logic [13:0] CsrCrmd   = 14'h0;
  localparam logic [13:0] CsrPrmd   = 14'h1;
  localparam logic [13:0] CsrEcfg   = 14'h4;
  localparam logic [13:0] CsrEstat  = 14'h5;
  localparam logic [13:0] CsrEra    = 14'h6;
  localparam logic [13:0] CsrBadv   = 14'h7;
  localparam logic [13:0] CsrEentry = 14'hC;
  localparam logic [13:0] CsrSave0  = 14'h30;
  localparam logic [13:0] CsrTid    = 14'h40;
  localparam logic [13:0] CsrTcfg   = 14'h41;
  localparam logic [13:0] CsrTval   = 14'h42;
  localparam logic [13:0] CsrTiclr  = 14'h44;

  localparam logic [12:0] EcfgMask  = 13'h1BFF;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val,
                                        input logic [31:0] mask);
    return (old & ~mask) | (val & mask);
  endfunction

  // crmd/prmd hold {IE, PLV[1:0]} in the same layout
  logic [2:0]  crmd_q, crmd_d;
  logic [2:0]  prmd_q, prmd_d;
  logic [12:0] ecfg_q, ecfg_d;
  logic [1:0]  is_sw_q, is_sw_d;
  logic [7:0]  is_hw_q;
  logic        is_timer_q, is_timer_d;
  logic        is_ipi_q;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [25:0] eentry_q, eentry_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;

  logic        wr_en;
  logic [12:0] is_all;
  logic [31:0] estat_rd;
  logic [31:0] tcfg_new;
  logic        tcfg_wr;
  logic        timer_set;
  logic        ticlr_clr;

  assign wr_en    = csr_we & ~wb_ex & ~ertn_flush;
  assign is_all   = {is_ipi_q, is_timer_q, 1'b0, is_hw_q, is_sw_q};
  assign estat_rd = {1'b0, esubcode_q, ecode_q, 3'b000, is_all};
  assign tcfg_new = merge(tcfg_q, csr_wvalue, csr_wmask);
  assign tcfg_wr  = wr_en && (csr_num == CsrTcfg);
  // A TCFG write reloads TVAL, so it never counts as a 1->0 expiry
  assign timer_set = ~tcfg_wr & tcfg_q[0] & (tval_q == 32'd1);
  assign ticlr_clr = wr_en && (csr_num == CsrTiclr) && csr_wvalue[0] && csr_wmask[0];

  always_comb begin
    logic [31:0] m;
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    ecfg_d     = ecfg_q;
    is_sw_d    = is_sw_q;
    ecode_d    = ecode_q;
    esubcode_d = esubcode_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    for (int i = 0; i < 4; i++) save_d[i] = save_q[i];
    m = 32'h0;

    if (wb_ex) begin
      prmd_d     = crmd_q;
      crmd_d     = 3'b000;
      ecode_d    = wb_ecode;
      esubcode_d = wb_esubcode;
      era_d      = wb_pc;
      if (wb_ecode == 6'h08 && wb_esubcode == 9'h0) begin
        badv_d = wb_pc;
      end else if (wb_ecode == 6'h09) begin
        badv_d = wb_vaddr;
      end
    end else if (ertn_flush) begin
      crmd_d = prmd_q;
    end else if (wr_en) begin
      case (csr_num)
        CsrCrmd:   begin m = merge({29'h0, crmd_q}, csr_wvalue, csr_wmask); crmd_d = m[2:0]; end
        CsrPrmd:   begin m = merge({29'h0, prmd_q}, csr_wvalue, csr_wmask); prmd_d = m[2:0]; end
        CsrEcfg:   begin
          m = merge({19'h0, ecfg_q}, csr_wvalue, csr_wmask);
          ecfg_d = m[12:0] & EcfgMask;
        end
        CsrEstat:  begin m = merge({30'h0, is_sw_q}, csr_wvalue, csr_wmask); is_sw_d = m[1:0]; end
        CsrEra:    era_d = merge(era_q, csr_wvalue, csr_wmask);
        CsrBadv:   badv_d = merge(badv_q, csr_wvalue, csr_wmask);
        CsrEentry: begin
          m = merge({eentry_q, 6'h0}, csr_wvalue, csr_wmask);
          eentry_d = m[31:6];
        end
        CsrTid:    tid_d = merge(tid_q, csr_wvalue, csr_wmask);
        CsrTcfg:   tcfg_d = tcfg_new;
        default: begin
          for (int i = 0; i < 4; i++) begin
            if (csr_num == CsrSave0 + 14'(i)) save_d[i] = merge(save_q[i], csr_wvalue, csr_wmask);
          end
        end
      endcase
    end
  end

  always_comb begin
    tval_d = tval_q;
    if (tcfg_wr) begin
      tval_d = {tcfg_new[31:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != 32'h0) begin
        tval_d = tval_q - 32'd1;
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    is_timer_d = is_timer_q;
    if (timer_set) begin
      is_timer_d = 1'b1;
    end else if (ticlr_clr) begin
      is_timer_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_q     <= 3'b000;
      prmd_q     <= 3'b000;
      ecfg_q     <= 13'h0;
      is_sw_q    <= 2'b00;
      is_hw_q    <= 8'h0;
      is_timer_q <= 1'b0;
      is_ipi_q   <= 1'b0;
      ecode_q    <= 6'h0;
      esubcode_q <= 9'h0;
      era_q      <= 32'h0;
      badv_q     <= 32'h0;
      eentry_q   <= 26'h0;
      for (int i = 0; i < 4; i++) save_q[i] <= 32'h0;
      tid_q      <= TID_RST;
      tcfg_q     <= 32'h0;
      tval_q     <= 32'h0;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_q     <= ecfg_d;
      is_sw_q    <= is_sw_d;
      is_hw_q    <= hw_int_in;
      is_timer_q <= is_timer_d;
      is_ipi_q   <= ipi_int_in;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
      tid_q      <= tid_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
    end
  end

  always_comb begin
    csr_rvalue = 32'h0;
    if (csr_re) begin
      case (csr_num)
        CsrCrmd:   csr_rvalue = {28'h0, 1'b1, crmd_q};
        CsrPrmd:   csr_rvalue = {29'h0, prmd_q};
        CsrEcfg:   csr_rvalue = {19'h0, ecfg_q};
        CsrEstat:  csr_rvalue = estat_rd;
        CsrEra:    csr_rvalue = era_q;
        CsrBadv:   csr_rvalue = badv_q;
        CsrEentry: csr_rvalue = {eentry_q, 6'h0};
        CsrTid:    csr_rvalue = tid_q;
        CsrTcfg:   csr_rvalue = tcfg_q;
        CsrTval:   csr_rvalue = tval_q;
        default: begin
          for (int i = 0; i < 4; i++) begin
            if (csr_num == CsrSave0 + 14'(i)) csr_rvalue = save_q[i];
          end
        end
      endcase
    end
  end

  assign ex_entry   = {eentry_q, 6'h0};
  assign ertn_entry = era_q;
  assign has_int    = crmd_q[2] & |(is_all & ecfg_q);

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Control/status register file at the receiving end of the writeback-stage exception interface.
- Sinks the WB-stage exception and ertn events, plus the CSR read/write port used by csrrd/csrwr/csrxchg.
- Maintains CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3/TID/TCFG/TVAL/TICLR and the constant timer.
- Returns the redirect targets (exception entry, ertn return) and the pending-interrupt flag to the front of the pipeline.

Parameters:
- TID_RST, 32'h0, reset value of TID.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- csr_re  input  1  read enable (read path is combinational; rvalue is valid whenever re=1)
- csr_num  input  14  CSR address for both the read and the write port
- csr_rvalue  output  32  read data
- csr_we  input  1  write enable
- csr_wmask  input  32  per-bit write mask
- csr_wvalue  input  32  write data
- wb_ex  input  1  exception commit from WB
- wb_ecode  input  6  exception code
- wb_esubcode  input  9  exception subcode
- wb_pc  input  32  PC of the excepting or ertn instruction
- wb_vaddr  input  32  faulting data address
- ertn_flush  input  1  ertn commit from WB
- hw_int_in  input  8  hardware interrupt lines (level)
- ipi_int_in  input  1  inter-processor interrupt (level)
- ex_entry  output  32  equals EENTRY
- ertn_entry  output  32  equals ERA
- has_int  output  1  interrupt pending and enabled

Behaviour:
- Register addresses: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Unimplemented addresses read 0 and ignore writes.
- csr_rvalue = 0 when csr_re=0.
- Reset values:
  - CRMD = 32'h8 (DA=1, PLV=0, IE=0).
  - TID = TID_RST.
  - All other registers = 0.
  - Outputs follow from the register state: ex_entry=0, ertn_entry=0, has_int=0.
- Masked write, applied on the clock edge: new = (old & ~wmask) | (wvalue & wmask), restricted to the writable fields below. Non-writable bits keep their value and read as their fixed value.
  - CRMD: PLV[1:0], IE[2] writable; DA[3] reads 1; other bits read 0.
  - PRMD: [2:0] writable.
  - ECFG: [12:11] and [9:0] writable.
  - ESTAT: only IS[1:0] is software-writable.
  - ERA, BADV, SAVE0-3, TID: all 32 bits writable.
  - EENTRY: [31:6] writable; [5:0] read 0.
  - TCFG: [31:0] writable, with En=bit0, Periodic=bit1, InitVal=[31:2].
  - TVAL: read-only.
  - TICLR: reads 0; a write with effective bit0=1 clears ESTAT.IS[11].
- Event priority within one cycle: wb_ex > ertn_flush > csr_we. csr_we is ignored in any cycle where wb_ex or ertn_flush is 1.
- On wb_ex=1, in the same edge:
  - PRMD.PPLV <= CRMD.PLV and PRMD.PPIE <= CRMD.IE.
  - CRMD.PLV <= 0 and CRMD.IE <= 0.
  - ESTAT.Ecode[21:16] <= wb_ecode and ESTAT.EsubCode[30:22] <= wb_esubcode.
  - ERA <= wb_pc.
  - BADV <= wb_pc when ecode=0x08 and esubcode=0 (ADEF).
  - BADV <= wb_vaddr when ecode=0x09 (ALE).
  - BADV is unchanged for all other ecodes.
- On ertn_flush=1 (and wb_ex=0): CRMD.PLV <= PRMD.PPLV and CRMD.IE <= PRMD.PPIE.
- ESTAT.IS sources:
  - IS[9:2] <= hw_int_in, sampled every cycle.
  - IS[12] <= ipi_int_in, sampled every cycle.
  - IS[11] is the timer flag.
  - IS[10] reads 0.
- Timer:
  - A TCFG write loads TVAL <= {written InitVal, 2'b00}.
  - Otherwise, while En=1 and TVAL!=0, TVAL decrements by 1 per cycle.
  - On the edge where TVAL goes 1->0 with En=1, IS[11] <= 1.
  - When TVAL==0 and En=1: if Periodic=1, TVAL reloads {InitVal,2'b00} on the next edge; if Periodic=0, TVAL holds 0.
  - If the timer set and a TICLR clear occur in the same cycle, the set wins.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Combinational from registers.
- Reset asserted mid-operation returns every register to its reset value on that edge and overrides all events.

Test Plan:
1. Reset; read 0x0, 0x5, 0xC -> 32'h8, 0, 0; has_int=0.
2. Write CRMD with wvalue=7, wmask=FFFFFFFF -> reads 32'hF. Then wb_ex with ecode=0x0B, wb_pc=1C00_0100 -> ERA=1C00_0100, PRMD=7, CRMD=8, ESTAT[21:16]=0x0B. Then ertn_flush -> CRMD=F.
3. wb_ex with ecode=0x09, vaddr=0000_1003 -> BADV=0000_1003. wb_ex with ecode=0x08, esubcode=0, pc=0000_0002 -> BADV=0000_0002.
4. Write EENTRY=FFFF_FFFF -> ex_entry=FFFF_FFC0. Same-cycle wb_ex with csr_we to ERA -> ERA=wb_pc (write dropped).
5. TCFG=0x0000_000D (InitVal=3, Periodic=0, En=1) -> TVAL=12, counts down to 0, IS[11]=1, TVAL holds 0. With ECFG.LIE[11]=1 and CRMD.IE=1 -> has_int=1. TICLR write 1 -> IS[11]=0, has_int=0.
6. TCFG=0x0000_000B (Periodic=1, InitVal=2) -> TVAL cycles 8..0, reloads 8; IS[11] sets on each 1->0. hw_int_in=8'h01 -> ESTAT bit2=1 the next cycle.
